hid_bus_arbiter: RTL
====================

# hid_bus_arbiter

Two-port arbiter sharing the single HID peripheral bus (`hid_en`/`hid_be`/`hid_addr`/`hid_wrdata`/`hid_rddata`) between the core's MMIO path (port 0) and a second master such as a boot/debug loader (port 1). It sits between the masters and the HID subsystem (framebuffer, keyboard FIFO) in the `msoc_clk` domain. Arbitration is round-robin with bounded bursts, and there is one access per cycle. Read data is routed back to the issuing port one cycle later. Reads are never speculative, so keyboard-FIFO pops happen only for granted requests.

## Interface
- `MAX_BURST`, 4: maximum consecutive accepted beats per owner before re-arbitration (1..15).
- `msoc_clk` input 1: sole clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mN_req` input 1: port N (N∈{0,1}) requests an access. Request fields must stay stable until accepted.
- `mN_we` input 1: 1 means write, 0 means read.
- `mN_be` input 8: byte enables.
- `mN_addr` input 19: HID address (bits [18:15] select the region).
- `mN_wrdata` input 64: write data.
- `mN_gnt` output 1: the access is accepted this cycle when `mN_req & mN_gnt`.
- `mN_rvalid` output 1: read data for port N is valid this cycle.
- `mN_rddata` output 64: equals `hid_rddata` when `mN_rvalid` is high, otherwise 0.
- `hid_en` output 1: HID bus strobe.
- `hid_be` output 8: byte enables to HID.
- `hid_addr` output 19: address to HID.
- `hid_wrdata` output 64: write data to HID.
- `hid_rddata` input 64: HID read data, valid one cycle after `hid_en`.
- `hid_owner` output 1: the port that holds the current burst. Debug visibility only.

## Operation
**State**
- `own_vld`, `owner`, `beats[3:0]`, `rr_ptr`.
- `rd_pend` and `rd_port` form the read-return slot.

**Grant rules, evaluated combinationally each cycle; at most one `gnt` is high**
- **Continuation:** if `own_vld` is set, `m[owner]_req` is high and `beats < MAX_BURST`, grant `owner`.
- **Otherwise, arbitration:** if both ports request, grant `rr_ptr`. If one port requests, grant it. If neither requests, no grant.
- **Burst limit reached:** a port with `beats == MAX_BURST` that is the sole requester is re-granted, and this starts a new burst.

**Bus drive**
- `hid_en = |(mN_req & mN_gnt)`.
- `hid_be`, `hid_addr` and `hid_wrdata` are muxed from the granted port. They are 0 when nothing is granted.

**Register updates on acceptance**
- Continuation: `beats++`.
- New burst: `owner ← winner`, `own_vld ← 1`, `beats ← 1`, `rr_ptr ← ~winner`.
- No acceptance: `own_vld ← 0`, `beats ← 0`.

**Read return**
- On accepting a read: `rd_pend ← 1`, `rd_port ← winner`. Otherwise `rd_pend ← 0`.
- `mN_rvalid = rd_pend & (rd_port == N)`.
- Writes produce no `rvalid`.

**Other rules**
- Dropping `req` ends the burst. No bubble is inserted: the other port may be granted in the same cycle.
- A write with `be == 0` is still issued (`hid_en=1`, `hid_be=0`).

## Timing
- Grant is zero-latency (combinational from `req`). Throughput is one beat per cycle.
- Read latency: accepted in cycle T, `rvalid`/`rddata` in cycle T+1. Back-to-back reads from alternating ports return in issue order.
- Reset values:
  - Registers: `own_vld=0`, `owner=0`, `beats=0`, `rr_ptr=0`, `rd_pend=0`.
  - Outputs: `gnt=0` (until inputs are sampled after reset), `rvalid=0`, `rddata=0`, `hid_owner=0`.
  - `hid_en=0` while `rst` is high. Grants are suppressed during reset.
- Reset mid-operation: a read accepted in the cycle before `rst` still had its HID strobe, but its `rvalid` is dropped. Burst state clears.
- Simultaneous first requests after reset: port 0 wins (`rr_ptr=0`).
- `beats` saturates its meaning at `MAX_BURST` and never wraps. With `MAX_BURST=1`, ports alternate every beat under contention.

## Configuration
- `HID_ARB_RR_EN` defined: round-robin behaviour as above.
- `HID_ARB_RR_EN` undefined: fixed priority.
  - `rr_ptr` is held at 0, so port 0 wins every arbitration.
  - Port 0 preempts port 1 at port 1's burst boundary.
  - The continuation rule and `MAX_BURST` still apply to both ports.

## Test plan
- **Single read:** port 0 reads `addr=0x30000`, `hid_rddata=0x0000_0000_0000_01AB` in T+1 → `m0_rvalid=1`, `m0_rddata=0x1AB` at T+1 only; `m1_rvalid=0`.
- **Contention, `MAX_BURST=4`, RR on:** both ports request continuously → grants go 0,0,0,0,1,1,1,1,0… and `hid_en` is high every cycle.
- **Burst release:** port 0 holds `req` for 2 beats, then drops it while port 1 is requesting → port 1 is granted in the same cycle `m0_req` falls, with no idle cycle.
- **Keyboard pop safety:** port 1 requests a read at `0x30000` while port 0 holds the burst → `hid_en` is high only for port 0 addresses until port 1's grant, then exactly one cycle with `hid_addr=0x30000`.
- **Reset mid-read:** port 0 read accepted at T, `rst=1` at T+1 → `m0_rvalid=0` at T+1. After `rst` falls, simultaneous requests grant port 0 first.
- **`HID_ARB_RR_EN` undefined:** both ports request continuously → grants go 0,0,0,0,0,0,… while port 1 sees no grant. When port 0 drops `req`, port 1 bursts until port 0 reasserts and port 1's burst ends.

Source files
------------

// File: rtl/hid_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : hid_bus_arbiter_if                                             |
// | Purpose   : One master-side channel into the HID bus arbiter. A master     |
// |             presents a request (req/we/be/addr/wrdata). The arbiter        |
// |             answers with a zero-latency grant and a one-cycle-delayed      |
// |             read return.                                                   |
// | Signals   : req     - access request; fields held stable until accepted    |
// |             we      - 1 = write, 0 = read                                  |
// |             be      - byte enables [7:0]                                   |
// |             addr    - HID address [18:0] (bits [18:15] select the region)  |
// |             wrdata  - write data [63:0]                                    |
// |             gnt     - access accepted this cycle when req & gnt            |
// |             rvalid  - read data for this channel is valid this cycle       |
// |             rddata  - read data [63:0], zero when rvalid is low            |
// | Modports  : master (drives the request), slave (the arbiter side)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface hid_bus_arbiter_if;

  logic        req;
  logic        we;
  logic [7:0]  be;
  logic [18:0] addr;
  logic [63:0] wrdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rddata;

  modport master (
    output req,
    output we,
    output be,
    output addr,
    output wrdata,
    input  gnt,
    input  rvalid,
    input  rddata
  );

  modport slave (
    input  req,
    input  we,
    input  be,
    input  addr,
    input  wrdata,
    output gnt,
    output rvalid,
    output rddata
  );

endinterface : hid_bus_arbiter_if
`default_nettype wire

// File: rtl/hid_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : hid_bus_arbiter                                                |
// | Purpose   : Shares the single HID peripheral bus between two masters.      |
// |             Port 0 is the core MMIO path. Port 1 is a boot/debug loader.   |
// |             The bus carries one access per cycle. Ownership is arbitrated  |
// |             in bounded bursts. Read data goes back to the issuing port     |
// |             one cycle after the strobe. Only granted requests reach the    |
// |             bus, so keyboard-FIFO pops are never speculative.              |
// | Clock     : msoc_clk, rising edge only                                     |
// | Reset     : rst, synchronous, active high                                  |
// | Ports     : m0, m1      - master channels (hid_bus_arbiter_if.slave)       |
// |             hid_en      - HID bus strobe                                   |
// |             hid_be      - byte enables to HID (0 when idle)                |
// |             hid_addr    - address to HID (0 when idle)                     |
// |             hid_wrdata  - write data to HID (0 when idle)                  |
// |             hid_rddata  - HID read data, valid one cycle after hid_en      |
// |             hid_owner   - port holding the current burst (debug only)      |
// | Params    : MAX_BURST   - beats one owner may take back to back before     |
// |                           re-arbitration (legal range 1..15)               |
// | Options   : HID_ARB_RR_EN - when defined, ties are broken round-robin.     |
// |                           When undefined, port 0 has fixed priority and    |
// |                           takes the bus at every arbitration point.        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module hid_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic                    msoc_clk,
  input  logic                    rst,
  hid_bus_arbiter_if.slave        m0,
  hid_bus_arbiter_if.slave        m1,
  output logic                    hid_en,
  output logic [7:0]              hid_be,
  output logic [18:0]             hid_addr,
  output logic [63:0]             hid_wrdata,
  input  logic [63:0]             hid_rddata,
  output logic                    hid_owner
);

  // The beat counter is 4 bits wide, which is enough for the legal range.
  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic       own_vld_q, own_vld_d;   // a burst is in progress
  logic       owner_q,   owner_d;     // port holding (or last holding) the bus
  logic [3:0] beats_q,   beats_d;     // beats accepted in the current burst
  logic       rr_ptr_q,  rr_ptr_d;    // port that wins the next tie
  logic       rd_pend_q, rd_pend_d;   // a read was strobed last cycle
  logic       rd_port_q, rd_port_d;   // port that issued that read

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  logic w_owner_req;  // current owner is still requesting
  logic w_cont;       // current owner may keep the bus for another beat
  logic w_accept;     // some port is granted this cycle
  logic w_winner;     // which port that is (meaningful only when w_accept)
  logic w_win_we;     // direction of the winning access

  always_comb begin
    w_owner_req = owner_q ? m1.req : m0.req;
    // Continuation needs a live burst whose owner still requests and has not
    // used up its beat allowance. At the limit the owner falls back to
    // ordinary arbitration. As the sole requester it wins again, and that
    // starts a fresh burst.
    w_cont      = own_vld_q & w_owner_req & (beats_q < c_max_burst);

    w_accept = 1'b0;
    w_winner = 1'b0;
    // Nothing is granted while reset is asserted, so no HID strobe can leak
    // out during reset.
    if (!rst) begin
      if (w_cont) begin
        w_accept = 1'b1;
        w_winner = owner_q;
      end else if (m0.req && m1.req) begin
        w_accept = 1'b1;
        w_winner = rr_ptr_q;
      end else if (m0.req) begin
        w_accept = 1'b1;
        w_winner = 1'b0;
      end else if (m1.req) begin
        w_accept = 1'b1;
        w_winner = 1'b1;
      end
    end

    w_win_we = w_winner ? m1.we : m0.we;
  end

  // Grants go only to a requesting port, so req & gnt reduces to the grant.
  assign m0.gnt = w_accept & ~w_winner;
  assign m1.gnt = w_accept &  w_winner;

  // --------------------------------------------------------------------------
  // HID bus drive: a mux from the winner, forced to zero when idle
  // --------------------------------------------------------------------------
  always_comb begin
    hid_en     = w_accept;
    hid_be     = '0;
    hid_addr   = '0;
    hid_wrdata = '0;
    if (w_accept) begin
      if (w_winner) begin
        hid_be     = m1.be;
        hid_addr   = m1.addr;
        hid_wrdata = m1.wrdata;
      end else begin
        hid_be     = m0.be;
        hid_addr   = m0.addr;
        hid_wrdata = m0.wrdata;
      end
    end
  end

  assign hid_owner = owner_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    own_vld_d = own_vld_q;
    owner_d   = owner_q;
    beats_d   = beats_q;
    rr_ptr_d  = rr_ptr_q;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;

    if (w_accept) begin
      if (w_cont) begin
        // Bounded by c_max_burst through w_cont, so this never wraps.
        beats_d = beats_q + 4'd1;
      end else begin
        owner_d   = w_winner;
        own_vld_d = 1'b1;
        beats_d   = 4'd1;
`ifdef HID_ARB_RR_EN
        rr_ptr_d  = ~w_winner;
`else
        // Fixed priority: port 0 wins every tie.
        rr_ptr_d  = 1'b0;
`endif
      end
      // Only reads occupy the return slot. Writes produce no rvalid.
      rd_pend_d = ~w_win_we;
      rd_port_d = w_winner;
    end else begin
      // An idle cycle ends any burst. The owner is kept for hid_owner.
      own_vld_d = 1'b0;
      beats_d   = 4'd0;
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      own_vld_q <= 1'b0;
      owner_q   <= 1'b0;
      beats_q   <= 4'd0;
      rr_ptr_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      own_vld_q <= own_vld_d;
      owner_q   <= owner_d;
      beats_q   <= beats_d;
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read return
  // --------------------------------------------------------------------------
  // A read strobed just before reset still reached HID. Its return is
  // suppressed combinationally, so the master never sees data in the first
  // reset cycle.
  logic w_rvalid0;
  logic w_rvalid1;

  assign w_rvalid0 = rd_pend_q & ~rst & ~rd_port_q;
  assign w_rvalid1 = rd_pend_q & ~rst &  rd_port_q;

  assign m0.rvalid = w_rvalid0;
  assign m1.rvalid = w_rvalid1;
  assign m0.rddata = w_rvalid0 ? hid_rddata : '0;
  assign m1.rddata = w_rvalid1 ? hid_rddata : '0;

endmodule : hid_bus_arbiter
`default_nettype wire
